// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA engine.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0]  DMA_REG_ADDR = 16'h4014;
    localparam int unsigned  OAM_WORDS    = 256;

endpackage

// File: rtl/oam_dma_engine.sv
// Sprite DMA sequencer: copies XFER_LEN bytes from a WRAM page into OAM while stalling the CPU.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN tick after HALT.
module oam_dma_engine
    import nes_dma_pkg::*;
#(
    parameter int unsigned XFER_LEN = 256,
    parameter int unsigned SRC_AW   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              start,
    input  logic [7:0]        page,
    input  logic [7:0]        oam_base,
    output logic              cpu_stall,
    output logic              src_req,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [7:0]        src_rdata,
    output logic [7:0]        oam_addr,
    output logic              oam_wren,
    output logic [7:0]        oam_wdata,
    output logic              busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] oam_base_q, oam_base_d;
    logic [7:0] oam_addr_q, oam_addr_d;
    logic       parity_q, parity_d;
    logic       busy_q, busy_d;

    // Next-state and datapath; the start edge is accepted without ce.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        page_d     = page_q;
        oam_base_d = oam_base_q;
        parity_d   = parity_q ^ ce;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HALT;
                    idx_d      = 8'd0;
                    page_d     = page;
                    oam_base_d = oam_base;
                end
            end
            HALT: begin
                if (ce) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = parity_q ? ALIGN : READ;
`else
                    state_d = READ;
`endif
                end
            end
            ALIGN: begin
                if (ce) state_d = READ;
            end
            READ: begin
                if (ce) state_d = WRITE;
            end
            WRITE: begin
                if (ce) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        oam_addr_d = oam_base_d + idx_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            page_q     <= 8'd0;
            oam_base_q <= 8'd0;
            oam_addr_q <= 8'd0;
            parity_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            oam_base_q <= oam_base_d;
            oam_addr_q <= oam_addr_d;
            parity_q   <= parity_d;
            busy_q     <= busy_d;
        end
    end

    assign cpu_stall = busy_q;
    assign src_req   = busy_q;
    assign busy      = busy_q;
    assign src_addr  = SRC_AW'({page_q, idx_q});
    assign oam_addr  = oam_addr_q;
    // Write strobe qualifies with ce so the commit lands on the WRITE ce edge only.
    assign oam_wren  = ce & (state_q == WRITE);
    assign oam_wdata = (state_q == WRITE) ? src_rdata : 8'h00;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed self-checking bench for oam_dma_engine with WRAM and OAM behavioural models.
module tb_oam_dma_engine;

`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN_ON = 1;
`else
    localparam int ALIGN_ON = 0;
`endif

    logic        clock;
    logic        reset_n;
    logic        ce = 1'b0;
    logic        start;
    logic [7:0]  page;
    logic [7:0]  oam_base;
    logic        cpu_stall;
    logic        src_req;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic [7:0]  oam_addr;
    logic        oam_wren;
    logic [7:0]  oam_wdata;
    logic        busy;

    oam_dma_engine #(.XFER_LEN(256), .SRC_AW(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce        (ce),
        .start     (start),
        .page      (page),
        .oam_base  (oam_base),
        .cpu_stall (cpu_stall),
        .src_req   (src_req),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .oam_addr  (oam_addr),
        .oam_wren  (oam_wren),
        .oam_wdata (oam_wdata),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] wram [0:65535];
    logic [7:0] oam_m [0:255];
    logic [7:0] wr_log [0:7];
    int   wr_cnt, tick_cnt, bad_wr, bad_hold;
    logic clr = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_ce = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic par_m;
    int   ce_div = 1;
    int   ce_ph = 0;
    logic exp_par;
    int   loop_n;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // WRAM read port: registered, one-clock latency.
    always @(posedge clock) src_rdata <= wram[src_addr];

    // Reference parity flop.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) par_m <= 1'b0;
        else if (ce)  par_m <= ~par_m;
    end

    // ce generator: every clock or every ce_div-th clock.
    always begin
        @(posedge clock);
        #1;
        if (ce_div <= 1) begin
            ce = 1'b1;
        end else begin
            ce    = (ce_ph == 0);
            ce_ph = (ce_ph + 1) % ce_div;
        end
    end

    // OAM model and transfer monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) oam_m[i] = 8'hEE;
            wr_cnt = 0; tick_cnt = 0; bad_wr = 0; bad_hold = 0;
        end
        if (reset_n) begin
            if (oam_wren) begin
                if (wr_cnt < 8) wr_log[wr_cnt] = oam_addr;
                oam_m[oam_addr] = oam_wdata;
                wr_cnt++;
                if (!ce) bad_wr++;
            end
            if (busy && ce) tick_cnt++;
            if (busy && prev_busy && !prev_ce && src_addr != prev_addr) bad_hold++;
        end
        prev_busy = busy;
        prev_ce   = ce;
        prev_addr = src_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int count_bad(input logic [7:0] pg, input logic [7:0] base);
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            if (oam_m[a] !== wram[{pg, 8'(i)}]) n++;
        end
        return n;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"}, cpu_stall, 0);
        check({tag, "_req"},   src_req,   0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_saddr"}, src_addr,  0);
        check({tag, "_oaddr"}, oam_addr,  0);
        check({tag, "_wren"},  oam_wren,  0);
        check({tag, "_wdata"}, oam_wdata, 0);
    endtask

    // mode 0: plain run, 1: second start when oam_addr hits 'hit', 2: reset when idx hits 'hit'.
    task automatic run_xfer(input logic [7:0] pg, input logic [7:0] base, input int mode,
                            input logic [7:0] hit);
        bit acted = 0;
        clr      = 1'b1;
        page     = pg;
        oam_base = base;
        start    = 1'b1;
        tick();
        clr      = 1'b0;
        start    = 1'b0;
        exp_par  = par_m;
        loop_n   = 0;
        while (busy && loop_n < 5000) begin
            if (!acted && mode == 1 && oam_addr == hit) begin
                page  = 8'h07;
                start = 1'b1;
                tick();
                start = 1'b0;
                page  = pg;
                acted = 1;
                check("restart_page_held", src_addr[15:8], pg);
            end else if (!acted && mode == 2 && src_addr[7:0] == hit) begin
                reset_n = 1'b0;
                #1;
                check_outputs_zero("abort");
                acted = 1;
                tick();
                tick();
                reset_n = 1'b1;
                break;
            end else begin
                tick();
            end
            loop_n++;
        end
        if (mode != 2) check("xfer_timeout", loop_n < 5000, 1);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        page     = 8'h00;
        oam_base = 8'h00;
        for (int i = 0; i < 65536; i++) wram[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            wram[16'h0200 + i] = 8'(i) ^ 8'h5A;
            wram[16'h0300 + i] = 8'(i * 7 + 3);
            wram[16'h0700 + i] = 8'(i) ^ 8'hC3;
        end
        tick(); tick(); tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(); tick();
        check("idle_busy", busy, 0);

        // 1: page 2 to OAM base 0, ce every clock
        run_xfer(8'h02, 8'h00, 0, 8'h00);
        check("s1_data_bad",  count_bad(8'h02, 8'h00), 0);
        check("s1_oam0",      oam_m[0], 8'h5A);
        check("s1_oam255",    oam_m[255], 8'hA5);
        check("s1_writes",    wr_cnt, 256);
        check("s1_ticks",     tick_cnt, 513 + ((ALIGN_ON != 0 && exp_par) ? 1 : 0));
        check("s1_idle_busy", busy, 0);

        // 2: page 3 to wrapping base FC
        run_xfer(8'h03, 8'hFC, 0, 8'h00);
        check("s2_data_bad", count_bad(8'h03, 8'hFC), 0);
        check("s2_first_at", wr_log[0], 8'hFC);
        check("s2_fifth_at", wr_log[4], 8'h00);
        check("s2_oamFC",    oam_m[8'hFC], 8'h03);
        check("s2_oam00",    oam_m[8'h00], 8'h1F);
        check("s2_writes",   wr_cnt, 256);

        // 3: ce every third clock
        ce_div = 3;
        run_xfer(8'h02, 8'h00, 0, 8'h00);
        check("s3_data_bad", count_bad(8'h02, 8'h00), 0);
        check("s3_writes",   wr_cnt, 256);
        check("s3_ticks",    tick_cnt, 513 + ((ALIGN_ON != 0 && exp_par) ? 1 : 0));
        check("s3_wr_no_ce", bad_wr, 0);
        check("s3_hold",     bad_hold, 0);
        ce_div = 1;
        tick(); tick(); tick();

        // 4: second start mid-transfer is ignored
        run_xfer(8'h02, 8'h00, 1, 8'h40);
        check("s4_data_bad", count_bad(8'h02, 8'h00), 0);
        check("s4_writes",   wr_cnt, 256);
        check("s4_ticks",    tick_cnt, 513 + ((ALIGN_ON != 0 && exp_par) ? 1 : 0));

        // 5: reset at idx 0x10, then a fresh transfer
        run_xfer(8'h02, 8'h00, 2, 8'h10);
        begin
            int lo_bad = 0;
            int hi_bad = 0;
            for (int i = 0; i < 16; i++)  if (oam_m[i] !== (8'(i) ^ 8'h5A)) lo_bad++;
            for (int i = 16; i < 256; i++) if (oam_m[i] !== 8'hEE) hi_bad++;
            check("s5_written_lo", lo_bad, 0);
            check("s5_untouched_hi", hi_bad, 0);
            check("s5_writes", wr_cnt, 16);
        end
        check("s5_post_busy", busy, 0);
        run_xfer(8'h02, 8'h00, 0, 8'h00);
        check("s5_fresh_data", count_bad(8'h02, 8'h00), 0);
        check("s5_fresh_writes", wr_cnt, 256);

        // 6: latency with parity 0 then parity 1 at the HALT edge
        for (int p = 0; p < 2; p++) begin
            int guard = 0;
            while (par_m != ((p == 0) ? 1'b1 : 1'b0) && guard < 4) begin
                tick();
                guard++;
            end
            run_xfer(8'h03, 8'h10, 0, 8'h00);
            check(p == 0 ? "s6_ticks_even" : "s6_ticks_odd", tick_cnt,
                  513 + ((ALIGN_ON != 0 && p == 1) ? 1 : 0));
            check(p == 0 ? "s6_data_even" : "s6_data_odd", count_bad(8'h03, 8'h10), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
